// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the M-stage data-memory store buffer.
package dmem_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_AW    = 32;

    typedef struct packed {
        logic [SB_AW-3:0] widx;
        logic [31:0]      data;
    } sb_entry_t;

endpackage

// File: rtl/sb_youngest_match.sv
// Combinational search of the store buffer for the youngest valid entry
// whose word index matches the load address.
module sb_youngest_match
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]      valid,
    input  logic [PW-1:0]         tail,
    input  logic [SB_AW-3:0]      widx,
    output logic                  hit,
    output logic [31:0]           data
);

    logic [PW-1:0] idx;

    // Walk from the oldest slot (tail) to the youngest (tail-1); later hits overwrite.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = tail + PW'(k);
            if (valid[idx] && (entries[idx].widx == widx)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// In-order store buffer between the M stage and a handshaked RAM write port,
// with store-to-load forwarding from the youngest matching entry.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWriteM,
    input  logic          MemReadM,
    input  logic [AW-1:0] ALUResultM,
    input  logic [31:0]   WriteDataM,
    output logic [31:0]   ReadDataM,
    output logic          StallM,
    output logic          BufEmpty,
    output logic [AW-1:0] RamRdAddr,
    input  logic [31:0]   RamRdData,
    output logic          RamWrValid,
    input  logic          RamWrReady,
    output logic [AW-1:0] RamWrAddr,
    output logic [31:0]   RamWrData
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    sb_entry_t [DEPTH-1:0] entries;
    sb_entry_t             head_entry;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [PW-1:0]         offs;
    logic [CW-1:0]         count;
    logic [DEPTH-1:0]      valid;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  fwd_hit;
    logic [31:0]           fwd_data;

    assign full       = (count == CW'(DEPTH));
    assign RamWrValid = (count != '0);
    assign BufEmpty   = (count == '0);
    assign pop        = RamWrValid & RamWrReady;
    // A full buffer still accepts a store when the head drains on the same edge.
    assign StallM     = MemWriteM & full & ~pop;
    assign push       = MemWriteM & ~StallM;

    assign head_entry = entries[head];
    assign RamWrAddr  = {head_entry.widx, 2'b00};
    assign RamWrData  = head_entry.data;
    assign RamRdAddr  = ALUResultM;
    assign ReadDataM  = (MemReadM & ~MemWriteM & fwd_hit) ? fwd_data : RamRdData;

    always_comb begin
        valid = '0;
        offs  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs     = PW'(i) - head;
            valid[i] = ({1'b0, offs} < count);
        end
    end

    sb_youngest_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .entries (entries),
        .valid   (valid),
        .tail    (tail),
        .widx    (ALUResultM[AW-1:2]),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) entries[tail] <= {ALUResultM[AW-1:2], WriteDataM};
    end

    a_no_load_store_overlap: assert property (
        @(posedge clk) disable iff (!reset) !(MemWriteM && MemReadM)
    );

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench: expected RAM writes are queued as stores are accepted and
// compared in order as the buffer drains.
module tb_dmem_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic          clk;
    logic          reset;
    logic          MemWriteM;
    logic          MemReadM;
    logic [AW-1:0] ALUResultM;
    logic [31:0]   WriteDataM;
    logic [31:0]   ReadDataM;
    logic          StallM;
    logic          BufEmpty;
    logic [AW-1:0] RamRdAddr;
    logic [31:0]   RamRdData;
    logic          RamWrValid;
    logic          RamWrReady;
    logic [AW-1:0] RamWrAddr;
    logic [31:0]   RamWrData;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned occ    = 0;
    bit          alt    = 0;
    logic [31:0] ram10  = '0;

    dmem_store_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .BufEmpty   (BufEmpty),
        .RamRdAddr  (RamRdAddr),
        .RamRdData  (RamRdData),
        .RamWrValid (RamWrValid),
        .RamWrReady (RamWrReady),
        .RamWrAddr  (RamWrAddr),
        .RamWrData  (RamWrData)
    );

    assign RamRdData = RamRdAddr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference occupancy and drain-order model, evaluated between edges.
    always @(negedge clk) begin
        bit  m_pop;
        bit  m_stall;
        wr_t e;
        if (reset) begin
            m_pop   = (occ != 0) && RamWrReady;
            m_stall = MemWriteM && (occ == DEPTH) && !m_pop;
            check("wr_valid", RamWrValid, occ != 0);
            check("buf_empty", BufEmpty, occ == 0);
            if (MemWriteM) check("stall", StallM, m_stall);
            if (m_pop) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", RamWrAddr, e.addr);
                    check("wr_data", RamWrData, e.data);
                end
                if (RamWrAddr == 32'h10) ram10 = RamWrData;
                occ--;
            end
            if (MemWriteM && !m_stall) begin
                e.addr = {ALUResultM[31:2], 2'b00};
                e.data = WriteDataM;
                sb.push_back(e);
                occ++;
            end
            if (occ > DEPTH) check("occ_bound", occ, DEPTH);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        int unsigned tries = 0;
        bit acc = 0;
        MemWriteM  = 1'b1;
        ALUResultM = a;
        WriteDataM = d;
        do begin
            @(negedge clk);
            acc = !StallM;
            tick();
            tries++;
            if (alt) RamWrReady = ~RamWrReady;
        end while (!acc && tries < 50);
        if (!acc) check("store_timeout", 0, 1);
        MemWriteM = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp);
        MemReadM   = 1'b1;
        ALUResultM = a;
        @(negedge clk);
        check(tag, ReadDataM, exp);
        tick();
        MemReadM = 1'b0;
    endtask

    task automatic wait_empty();
        int unsigned n = 0;
        while (!BufEmpty && n < 100) begin
            tick();
            n++;
        end
        check("drain_done", BufEmpty, 1);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        reset      = 1'b0;
        MemWriteM  = 1'b0;
        MemReadM   = 1'b0;
        ALUResultM = '0;
        WriteDataM = '0;
        RamWrReady = 1'b0;
        #1;
        check("rst_valid", RamWrValid, 0);
        check("rst_empty", BufEmpty, 1);
        check("rst_stall", StallM, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Async reset with three entries pending.
        do_store(32'h40, 32'h1111);
        do_store(32'h44, 32'h2222);
        do_store(32'h48, 32'h3333);
        check("pre_rst_valid", RamWrValid, 1);
        reset = 1'b0;
        occ   = 0;
        sb.delete();
        #1;
        check("mid_rst_valid", RamWrValid, 0);
        check("mid_rst_empty", BufEmpty, 1);
        check("mid_rst_stall", StallM, 0);
        tick();
        reset      = 1'b1;
        RamWrReady = 1'b1;
        repeat (4) tick();

        // Single store, offered the next cycle and drained.
        do_store(32'h100, 32'hDEADBEEF);
        @(negedge clk);
        check("t2_valid", RamWrValid, 1);
        check("t2_addr", RamWrAddr, 32'h100);
        check("t2_data", RamWrData, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        check("t2_empty", BufEmpty, 1);
        tick();

        // Forwarding from the youngest match.
        RamWrReady = 1'b0;
        do_store(32'h10, 32'd1);
        do_store(32'h14, 32'd2);
        do_store(32'h10, 32'd3);
        do_load("ld_10", 32'h10, 32'd3);
        do_load("ld_13", 32'h13, 32'd3);
        do_load("ld_14", 32'h14, 32'd2);
        do_load("ld_18", 32'h18, 32'h18 ^ 32'hA5A5_0000);

        // In-order drain including the repeated word.
        RamWrReady = 1'b1;
        wait_empty();
        check("ram_10", ram10, 32'd3);

        // Full buffer: stall, then push+pop on the same edge.
        RamWrReady = 1'b0;
        for (int i = 0; i < 4; i++) do_store(32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
        MemWriteM  = 1'b1;
        ALUResultM = 32'h300;
        WriteDataM = 32'h55;
        @(negedge clk);
        check("full_stall", StallM, 1);
        tick();
        @(negedge clk);
        check("full_stall_hold", StallM, 1);
        tick();
        RamWrReady = 1'b1;
        @(negedge clk);
        check("pushpop_stall", StallM, 0);
        tick();
        RamWrReady = 1'b0;
        ALUResultM = 32'h304;
        WriteDataM = 32'h66;
        @(negedge clk);
        check("still_full", StallM, 1);
        tick();
        MemWriteM  = 1'b0;
        RamWrReady = 1'b1;
        wait_empty();

        // Pointer wrap with alternating ready.
        RamWrReady = 1'b0;
        alt        = 1;
        for (int i = 0; i < 2 * DEPTH + 1; i++) do_store(32'h400 + 32'(4 * i), $urandom);
        alt        = 0;
        RamWrReady = 1'b1;
        wait_empty();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
